// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - single-port RAM arbiter for data and instruction accesses
// Data write > data read > fetch; a one-word instruction buffer hides fetch latency.
module memory_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        dataMemoryReadEnable,
  input  logic        dataMemoryWriteEnable,
  input  logic [31:0] dataMemoryAddress,
  input  logic [31:0] dataMemoryDataIn,
  output logic [31:0] dataMemoryDataOut,
  output logic        dataMemoryReady,
  input  logic [31:0] instructionMemoryAddress,
  output logic        instructionMemorySuccess,
  output logic [31:0] instructionMemoryDataOut,
  output logic [11:0] ramAddress,
  output logic        ramReadEnable,
  output logic        ramWriteEnable,
  output logic [31:0] ramWriteData,
  input  logic [31:0] ramReadData
);

  typedef enum logic {D_IDLE, D_WAIT} d_state_e;

  d_state_e    d_state_q, d_state_d;
  logic        ib_valid_q, ib_valid_d;
  logic [11:0] ib_addr_q, ib_addr_d;
  logic [31:0] ib_data_q, ib_data_d;
  logic        fp_valid_q, fp_valid_d;
  logic [11:0] fp_addr_q, fp_addr_d;

  logic [11:0] data_word;
  logic [11:0] pc_word;
  logic        data_rd, data_wr, ib_hit, fp_bypass, fetch;
  logic        unused_addr_bits;

  assign data_word = dataMemoryAddress[13:2];
  assign pc_word   = instructionMemoryAddress[13:2];
  assign unused_addr_bits = ^{dataMemoryAddress[31:14], dataMemoryAddress[1:0],
                              instructionMemoryAddress[31:14], instructionMemoryAddress[1:0]};

  always_comb begin
    d_state_d                = d_state_q;
    data_rd                  = 1'b0;
    data_wr                  = 1'b0;
    dataMemoryReady          = 1'b0;
    dataMemoryDataOut        = 32'h0;
    ib_hit                   = 1'b0;
    fp_bypass                = 1'b0;
    fetch                    = 1'b0;
    instructionMemorySuccess = 1'b0;
    instructionMemoryDataOut = 32'h0;
    ramAddress               = 12'h0;
    ramReadEnable            = 1'b0;
    ramWriteEnable           = 1'b0;
    ramWriteData             = 32'h0;
    ib_valid_d               = ib_valid_q;
    ib_addr_d                = ib_addr_q;
    ib_data_d                = ib_data_q;
    fp_valid_d               = 1'b0;
    fp_addr_d                = 12'h0;

    if (!reset) begin
      ramWriteData = dataMemoryDataIn;
      case (d_state_q)
        D_IDLE: begin
          if (dataMemoryWriteEnable) begin
            data_wr         = 1'b1;
            dataMemoryReady = 1'b1;
          end else if (dataMemoryReadEnable) begin
            data_rd   = 1'b1;
            d_state_d = D_WAIT;
          end
        end
        D_WAIT: begin
          dataMemoryReady   = 1'b1;
          dataMemoryDataOut = ramReadData;
          d_state_d         = D_IDLE;
        end
        default: d_state_d = D_IDLE;
      endcase

      ib_hit    = ib_valid_q && (ib_addr_q == pc_word);
      fp_bypass = fp_valid_q && (fp_addr_q == pc_word);
      fetch     = !data_wr && !data_rd && !ib_hit && !fp_bypass;

      if (ib_hit) begin
        instructionMemorySuccess = 1'b1;
        instructionMemoryDataOut = ib_data_q;
      end else if (fp_bypass) begin
        instructionMemorySuccess = 1'b1;
        instructionMemoryDataOut = ramReadData;
      end

      ramWriteEnable = data_wr;
      ramReadEnable  = data_rd || fetch;
      if (data_wr || data_rd) begin
        ramAddress = data_word;
      end else if (fetch) begin
        ramAddress = pc_word;
      end

      fp_valid_d = fetch;
      fp_addr_d  = fetch ? pc_word : 12'h0;

      // A fill replaces the buffered word; a store racing the fill wins the data.
      if (data_wr && (data_word == ib_addr_q)) begin
        ib_valid_d = 1'b0;
      end
      if (fp_valid_q) begin
        ib_valid_d = 1'b1;
        ib_addr_d  = fp_addr_q;
        ib_data_d  = (data_wr && (data_word == fp_addr_q)) ? dataMemoryDataIn : ramReadData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_state_q  <= D_IDLE;
      ib_valid_q <= 1'b0;
      ib_addr_q  <= 12'h0;
      ib_data_q  <= 32'h0;
      fp_valid_q <= 1'b0;
      fp_addr_q  <= 12'h0;
    end else begin
      d_state_q  <= d_state_d;
      ib_valid_q <= ib_valid_d;
      ib_addr_q  <= ib_addr_d;
      ib_data_q  <= ib_data_d;
      fp_valid_q <= fp_valid_d;
      fp_addr_q  <= fp_addr_d;
    end
  end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 The block SHALL expose the following ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- dataMemoryReadEnable  input  1  MEM-stage load request, held until dataMemoryReady
- dataMemoryWriteEnable  input  1  MEM-stage store request
- dataMemoryAddress  input  32  MEM-stage byte address
- dataMemoryDataIn  input  32  store data
- dataMemoryDataOut  output  32  load result, valid while dataMemoryReady=1
- dataMemoryReady  output  1  data access completes this cycle; MEM stage stalls while low
- instructionMemoryAddress  input  32  fetch byte address (PC)
- instructionMemorySuccess  output  1  instructionMemoryDataOut holds the word at the current PC
- instructionMemoryDataOut  output  32  fetched instruction
- ramAddress  output  12  word address to the single-port RAM
- ramReadEnable  output  1  RAM read issue
- ramWriteEnable  output  1  RAM write issue
- ramWriteData  output  32  RAM write data
- ramReadData  input  32  RAM read data, valid the cycle after ramReadEnable

REQ-002 Clock is clk; reset is synchronous and active-high (fixed decision).

Function
REQ-003 Word address SHALL be byteAddress[13:2]; bits [1:0] and [31:14] are ignored.
REQ-004 At most one RAM access is issued per cycle; priority: data write > data read > instruction fetch.
REQ-005 Data FSM states: D_IDLE, D_WAIT.
REQ-006 D_IDLE + write enable: issue write combinationally the same cycle, dataMemoryReady=1, remain in D_IDLE.
REQ-007 D_IDLE + read enable (no write): issue read, dataMemoryReady=0, go to D_WAIT.
REQ-008 D_WAIT: no new data issue; dataMemoryReady=1, dataMemoryDataOut=ramReadData, return to D_IDLE unconditionally. Load latency is therefore exactly one stall cycle.
REQ-009 Read and write asserted together: the write wins and completes; the read is dropped.
REQ-010 The instruction buffer SHALL hold ibValid, ibAddr (12 bits) and ibData (32 bits).
REQ-011 Buffer hit = ibValid && ibAddr == word(instructionMemoryAddress). On a hit, success=1 and dataOut=ibData with zero latency.
REQ-012 Fetch pending register (fpValid, fpAddr) SHALL be set in any cycle a fetch is issued; otherwise cleared.
REQ-013 Fetch response: if fpValid is set, the buffer loads ramReadData at fpAddr on the clock edge.
REQ-014 Fetch response bypass: if fpValid && fpAddr == current word PC, success=1 and dataOut=ramReadData in that same cycle.
REQ-015 Fetch is issued only when no data access is issued, there is no buffer hit, and no matching fetch is pending (REQ-014).
REQ-016 A PC change (branch or flush) SHALL simply miss the buffer; stale responses still fill the buffer but never assert success for a different PC.
REQ-017 A data write whose word address equals ibAddr SHALL clear ibValid on that edge (invalidate); a simultaneous fill of the same word takes the written data.
REQ-018 When success=0, instructionMemoryDataOut SHALL be 0.
REQ-019 ramWriteData=dataMemoryDataIn always. When no access is issued, ramAddress=0.

Reset
REQ-020 While reset=1: data FSM goes to D_IDLE; ibValid, fpValid, ibAddr and ibData are cleared; no RAM access is issued; dataMemoryReady=0; instructionMemorySuccess=0; all data outputs are 0.
REQ-021 Reset asserted mid-load (D_WAIT) SHALL abort the load with no ready pulse; the first cycle after reset is D_IDLE.

Verification
REQ-022 Cold fetch: release reset with PC=0x00 and RAM[0]=0x00500093. Required: fetch issued in cycle 0; success=1 with 0x00500093 in cycle 1; buffer hit from cycle 2 onward.
REQ-023 Load under fetch: PC hit in the buffer, load from 0x40 with RAM[0x10]=0xDEADBEEF. Required: ready=0 in cycle N; ready=1 with 0xDEADBEEF in N+1; instruction success stays 1 throughout.
REQ-024 Store priority: store 0x12345678 to 0x80 while the buffer misses. Required: RAM write in the same cycle, ready=1, no fetch issued; fetch issued in the next cycle.
REQ-025 Self-modify: buffer holds word 0x04; store to 0x04. Required: ibValid cleared; the next cycle refetches and returns the new data.
REQ-026 Branch: PC changes 0x08 -> 0x20 in the response cycle of 0x08. Required: success=0 for 0x20; fetch of 0x20 issued; success=1 one cycle later.
REQ-027 Reset during D_WAIT: required ready never pulses; all outputs are 0 in the following cycle.
